// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: loads a clamped preset, decrements once per
// TICK_DIV-cycle tick while running, and pulses done when it reaches 00:00.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | preset loaded or after reset; waits for start on nonzero
// ST_RUN     | prescaler counting, digits decrement on each tick
// ST_PAUSE   | digits and prescaler frozen; start resumes partial second
// ST_EXPIRED | count reached 00:00 from RUN; only load leaves
module bcd_countdown_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] ld_m1,
  input  logic [3:0] ld_m0,
  input  logic [3:0] ld_s1,
  input  logic [3:0] ld_s0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       running,
  output logic       done,
  output logic       zero
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_TC  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [3:0]    dec_m1, dec_m0, dec_s1, dec_s0;
  logic          dec_zero;
  logic          tick;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  assign zero    = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd0);
  assign running = (state == ST_RUN);
  assign tick    = (presc == P_TC);

  // One-second BCD decrement with borrow ripple; never reached at 00:00.
  always_comb begin
    dec_m1 = m1;
    dec_m0 = m0;
    dec_s1 = s1;
    dec_s0 = s0 - 4'd1;
    if (s0 == 4'd0) begin
      dec_s0 = 4'd9;
      dec_s1 = s1 - 4'd1;
      if (s1 == 4'd0) begin
        dec_s1 = 4'd5;
        dec_m0 = m0 - 4'd1;
        if (m0 == 4'd0) begin
          dec_m0 = 4'd9;
          dec_m1 = m1 - 4'd1;
        end
      end
    end
  end

  assign dec_zero = (dec_m1 == 4'd0) && (dec_m0 == 4'd0) &&
                    (dec_s1 == 4'd0) && (dec_s0 == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      presc <= '0;
      m1    <= 4'd0;
      m0    <= 4'd0;
      s1    <= 4'd0;
      s0    <= 4'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        m1    <= clamp(ld_m1, 4'd5);
        m0    <= clamp(ld_m0, 4'd9);
        s1    <= clamp(ld_s1, 4'd5);
        s0    <= clamp(ld_s0, 4'd9);
        presc <= '0;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop && !zero) begin
              state <= ST_RUN;
              presc <= '0;
            end
          end
          ST_RUN: begin
            // stop outranks a coincident tick; the prescaler keeps its value
            if (stop) begin
              state <= ST_PAUSE;
            end else if (tick) begin
              presc <= '0;
              m1    <= dec_m1;
              m0    <= dec_m0;
              s1    <= dec_s1;
              s0    <= dec_s0;
              if (dec_zero) begin
                state <= ST_EXPIRED;
                done  <= 1'b1;
              end
            end else begin
              presc <= presc + P_ONE;
            end
          end
          ST_PAUSE: begin
            if (start && !stop) state <= ST_RUN;
          end
          ST_EXPIRED: begin
            state <= ST_EXPIRED;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
